// File: rtl/echo_gate_ctrl.sv
// echo_gate_ctrl: ultrasonic range measurement sequencer in front of the
// 9-bit ripple distance counter. It fires the trigger and clears the counter.
// While echo is high it gates a one-pulse-per-cm tick onto the counter clock.
// It then captures the settled count as dist_cm.
// Optional build macro: AUTO_TRIG_EN adds a free-running auto-repeat period
// counter. A period pulse that arrives while a measurement is in progress is
// deferred until the controller returns to IDLE.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | counter held clear, waiting for a start request
// TRIG      | trigger high for TRIG_CYC cycles, counter still clear
// WAIT_ECHO | waiting for an echo rise, bounded by ECHO_WAIT_CYC
// MEASURE   | echo high, tick pulses gated onto cnt_clk, tick count bounded
// SETTLE    | SETTLE_CYC cycles for the ripple counter to settle
// CAPTURE   | cnt_q latched into dist_cm, dist_valid pulsed
// FAIL      | timeout flag set, dist_cm left unchanged
// HOLDOFF   | waiting for echo low before re-arming

module echo_gate_ctrl #(
  parameter int TRIG_CYC      = 500,
  parameter int TICK_CYC      = 2900,
  parameter int MAX_CM        = 400,
  parameter int ECHO_WAIT_CYC = 1_500_000,
  parameter int SETTLE_CYC    = 4
`ifdef AUTO_TRIG_EN
  ,
  parameter int PERIOD_CYC    = 3_000_000
`endif
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       start,
  input  logic       echo,
  input  logic [8:0] cnt_q,
  output logic       trig,
  output logic       cnt_clear,
  output logic       cnt_clk,
  output logic [8:0] dist_cm,
  output logic       dist_valid,
  output logic       timeout,
  output logic       busy
);

  localparam int HALF    = TICK_CYC / 2;
  localparam int PH_W    = $clog2(TICK_CYC);
  localparam int TMR_MAX = (ECHO_WAIT_CYC > TRIG_CYC)
                         ? ((ECHO_WAIT_CYC > SETTLE_CYC) ? ECHO_WAIT_CYC : SETTLE_CYC)
                         : ((TRIG_CYC > SETTLE_CYC) ? TRIG_CYC : SETTLE_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Timer loads are terminal-count minus one so each phase lasts exactly N cycles.
  localparam logic [TMR_W-1:0] TRIG_LOAD   = TMR_W'(TRIG_CYC - 1);
  localparam logic [TMR_W-1:0] EWAIT_LOAD  = TMR_W'(ECHO_WAIT_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(TICK_CYC - 1);
  localparam logic [PH_W-1:0]  PH_HALF     = PH_W'(HALF);
  localparam logic [PH_W-1:0]  PH_HI_LAST  = PH_W'(HALF - 1);
  localparam logic [8:0]       TC_MAX      = 9'(MAX_CM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_SETTLE,
    S_CAPTURE,
    S_FAIL,
    S_HOLDOFF
  } state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [PH_W-1:0]   phase, phase_nxt;
  logic [8:0]        tc, tc_nxt;

  logic echo_m, echo_s, echo_s_d;
  logic echo_rise, echo_fall;
  logic go;

  assign echo_rise = echo_s & ~echo_s_d;
  assign echo_fall = ~echo_s & echo_s_d;

  // Two-flop synchroniser for the asynchronous echo, plus a delayed copy for edges.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      echo_m   <= 1'b0;
      echo_s   <= 1'b0;
      echo_s_d <= 1'b0;
    end else begin
      echo_m   <= echo;
      echo_s   <= echo_m;
      echo_s_d <= echo_s;
    end
  end

`ifdef AUTO_TRIG_EN
  localparam int PER_W = $clog2(PERIOD_CYC);
  localparam logic [PER_W-1:0] PER_LOAD = PER_W'(PERIOD_CYC - 1);

  logic [PER_W-1:0] per_cnt;
  logic             per_tick;
  logic             pend;

  assign per_tick = (per_cnt == '0);
  assign go       = start | pend | per_tick;

  // Free-running period down-counter; a pulse seen outside IDLE is held pending.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      per_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      per_cnt <= per_tick ? PER_LOAD : per_cnt - 1'b1;
      pend    <= (state == S_IDLE) ? 1'b0 : (pend | per_tick);
    end
  end
`else
  assign go = start;
`endif

  // State register and the timer, tick-phase and tick-count registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= S_IDLE;
      tmr   <= '0;
      phase <= '0;
      tc    <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      phase <= phase_nxt;
      tc    <= tc_nxt;
    end
  end

  // Next-state and counter-update logic.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    phase_nxt = phase;
    tc_nxt    = tc;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_nxt = S_TRIG;
          tmr_nxt   = TRIG_LOAD;
        end
      end
      S_TRIG: begin
        if (tmr == '0) begin
          state_nxt = S_WAIT_ECHO;
          tmr_nxt   = EWAIT_LOAD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_WAIT_ECHO: begin
        // An echo already high on entry produces no rise, so it is ignored.
        if (echo_rise) begin
          state_nxt = S_MEASURE;
          phase_nxt = '0;
          tc_nxt    = '0;
        end else if (tmr == '0) begin
          state_nxt = S_FAIL;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_MEASURE: begin
        if (echo_fall) begin
          state_nxt = S_SETTLE;
          tmr_nxt   = SETTLE_LOAD;
        end else if (tc == TC_MAX) begin
          state_nxt = S_FAIL;
        end else begin
          phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
          // A pulse counts as complete when its high half ends.
          if (phase == PH_HI_LAST) begin
            tc_nxt = tc + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (tmr == '0) begin
          state_nxt = S_CAPTURE;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_CAPTURE: state_nxt = S_HOLDOFF;
      S_FAIL:    state_nxt = S_HOLDOFF;
      S_HOLDOFF: begin
        if (!echo_s) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state so they align with the state register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      trig       <= 1'b0;
      cnt_clear  <= 1'b1;
      cnt_clk    <= 1'b0;
      busy       <= 1'b0;
      dist_cm    <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      trig       <= (state_nxt == S_TRIG);
      cnt_clear  <= (state_nxt == S_IDLE) || (state_nxt == S_TRIG);
      // Leaving MEASURE drops cnt_clk at once, so a partial high pulse ends cleanly.
      cnt_clk    <= (state_nxt == S_MEASURE) && (phase_nxt < PH_HALF);
      busy       <= (state_nxt != S_IDLE);
      dist_valid <= (state == S_CAPTURE);
      if (state == S_CAPTURE) begin
        dist_cm <= cnt_q;
      end
      if (state == S_FAIL) begin
        timeout <= 1'b1;
      end else if ((state == S_IDLE) && (state_nxt == S_TRIG)) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_echo_gate_ctrl.sv
// Directed bench for echo_gate_ctrl with a behavioural ripple counter on cnt_clk.
// Define AUTO_TRIG_EN to exercise the auto-repeat build instead of the port-driven tests.
module tb_echo_gate_ctrl;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       start;
  logic       echo;
  logic [8:0] cnt_q;
  logic       trig;
  logic       cnt_clear;
  logic       cnt_clk;
  logic [8:0] dist_cm;
  logic       dist_valid;
  logic       timeout;
  logic       busy;

  logic [8:0] cnt_model = '0;
  int n_tests = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int valid_cnt = 0;

  echo_gate_ctrl #(
    .TRIG_CYC(10),
    .TICK_CYC(20),
    .MAX_CM(30),
    .ECHO_WAIT_CYC(200),
    .SETTLE_CYC(4)
`ifdef AUTO_TRIG_EN
    ,
    .PERIOD_CYC(600)
`endif
  ) dut (
    .clk(clk),
    .clear_n(clear_n),
    .start(start),
    .echo(echo),
    .cnt_q(cnt_q),
    .trig(trig),
    .cnt_clear(cnt_clear),
    .cnt_clk(cnt_clk),
    .dist_cm(dist_cm),
    .dist_valid(dist_valid),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Ripple counter: counts on the falling edge of its clock, async clear.
  always @(negedge cnt_clk or posedge cnt_clear) begin
    if (cnt_clear) cnt_model <= '0;
    else           cnt_model <= cnt_model + 9'd1;
  end
  assign cnt_q = cnt_model;

  always @(posedge cnt_clk) pulse_cnt++;

  always @(negedge clk) begin
    if (dist_valid) valid_cnt++;
  end

`ifdef AUTO_TRIG_EN
  int stamps[8];
  int ns = 0;
  int cyc = 0;
  logic trig_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (trig && !trig_prev && ns < 8) begin
      stamps[ns] = cyc;
      ns++;
    end
    trig_prev = trig;
  end
`endif

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_trig"}, trig, 0);
    chk({pfx, "_cnt_clear"}, cnt_clear, 1);
    chk({pfx, "_cnt_clk"}, cnt_clk, 0);
    chk({pfx, "_dist_cm"}, dist_cm, 0);
    chk({pfx, "_dist_valid"}, dist_valid, 0);
    chk({pfx, "_timeout"}, timeout, 0);
    chk({pfx, "_busy"}, busy, 0);
  endtask

  // Start pulse, then measure trigger length; returns in the first WAIT_ECHO cycle.
  task automatic fire(output int trig_len, output int clr_bad);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    trig_len = 0;
    clr_bad = 0;
    while (trig && trig_len < 40) begin
      trig_len++;
      if (cnt_clear !== 1'b1) clr_bad++;
      tick(1);
    end
  endtask

  task automatic wait_idle(input int limit, output int waited);
    waited = 0;
    while (busy && waited < limit) begin
      tick(1);
      waited++;
    end
  endtask

  initial begin
    int tl, cb, w;
    clear_n = 1'b1;
    start = 1'b0;
    echo = 1'b0;
    #2;
    clear_n = 1'b0;
    #1;
    chk_reset("rst");
    tick(2);
    clear_n = 1'b1;
    tick(1);

`ifdef AUTO_TRIG_EN
    // Auto-repeat every 600 cycles with no start request.
    w = 0;
    while (ns < 4 && w < 2000) begin tick(1); w++; end
    chk("t6_four_trigs", int'(ns >= 4), 1);
    chk("t6_period_1", stamps[1] - stamps[0], 600);
    chk("t6_period_2", stamps[2] - stamps[1], 600);
    chk("t6_period_3", stamps[3] - stamps[2], 600);
    w = 0;
    while (trig && w < 40) begin tick(1); w++; end
    chk("t6_trig_done", trig, 0);
    // Long echo keeps the controller busy across the next period pulse.
    echo = 1'b1;
    tick(700);
    echo = 1'b0;
    chk("t6_busy_over_period", busy, 1);
    wait_idle(20, w);
    chk("t6_idle", busy, 0);
    tick(1);
    chk("t6_deferred_trig", trig, 1);
    w = 0;
    while (ns < 6 && w < 1000) begin tick(1); w++; end
    chk("t6_six_trigs", int'(ns >= 6), 1);
    chk("t6_deferred_late", int'(stamps[4] - stamps[3] > 600), 1);
    chk("t6_grid_kept", stamps[5] - stamps[3], 1200);
`else
    // 1: trigger pulse length and counter clear.
    pulse_cnt = 0;
    valid_cnt = 0;
    fire(tl, cb);
    chk("t1_trig_len", tl, 10);
    chk("t1_clear_in_trig", cb, 0);
    chk("t1_clear_after", cnt_clear, 0);
    chk("t1_busy", busy, 1);

    // 2: 250-cycle echo -> 13 pulses, dist 13.
    echo = 1'b1;
    tick(250);
    echo = 1'b0;
    wait_idle(60, w);
    chk("t2_idle", busy, 0);
    chk("t2_pulses", pulse_cnt, 13);
    chk("t2_dist", dist_cm, 13);
    chk("t2_valid_cnt", valid_cnt, 1);
    chk("t2_timeout", timeout, 0);
    chk("t2_counter_cleared", cnt_q, 0);

    // 3: no echo -> timeout after 200 WAIT_ECHO cycles.
    valid_cnt = 0;
    fire(tl, cb);
    w = 0;
    while (!timeout && w < 400) begin tick(1); w++; end
    chk("t3_wait_cycles", w, 201);
    chk("t3_busy_holdoff", busy, 1);
    tick(1);
    chk("t3_idle", busy, 0);
    chk("t3_dist_kept", dist_cm, 13);
    chk("t3_no_valid", valid_cnt, 0);

    // 4: echo stuck high -> 30 ticks then FAIL, held until echo falls.
    pulse_cnt = 0;
    valid_cnt = 0;
    fire(tl, cb);
    chk("t4_timeout_cleared", timeout, 0);
    echo = 1'b1;
    tick(700);
    chk("t4_pulses", pulse_cnt, 30);
    chk("t4_timeout", timeout, 1);
    chk("t4_busy_holdoff", busy, 1);
    chk("t4_cnt_clk_low", cnt_clk, 0);
    tick(300);
    echo = 1'b0;
    chk("t4_pulses_stopped", pulse_cnt, 30);
    chk("t4_still_busy", busy, 1);
    wait_idle(20, w);
    chk("t4_idle", busy, 0);
    chk("t4_dist_kept", dist_cm, 13);
    chk("t4_no_valid", valid_cnt, 0);
    chk("t4_timeout_held", timeout, 1);

    // 5: reset mid-MEASURE, then fresh measurements.
    fire(tl, cb);
    echo = 1'b1;
    tick(60);
    chk("t5_measuring", busy, 1);
    clear_n = 1'b0;
    #1;
    chk_reset("t5_rst");
    tick(2);
    echo = 1'b0;
    clear_n = 1'b1;
    tick(1);

    // Fall during the high half of the 7th pulse: partial pulse counts.
    pulse_cnt = 0;
    valid_cnt = 0;
    fire(tl, cb);
    echo = 1'b1;
    tick(125);
    echo = 1'b0;
    wait_idle(60, w);
    chk("t5a_idle", busy, 0);
    chk("t5a_pulses", pulse_cnt, 7);
    chk("t5a_dist", dist_cm, 7);
    chk("t5a_valid_cnt", valid_cnt, 1);
    chk("t5a_timeout", timeout, 0);

    // Fall in the low half: no extra pulse.
    pulse_cnt = 0;
    valid_cnt = 0;
    fire(tl, cb);
    echo = 1'b1;
    tick(115);
    echo = 1'b0;
    wait_idle(60, w);
    chk("t5b_idle", busy, 0);
    chk("t5b_pulses", pulse_cnt, 6);
    chk("t5b_dist", dist_cm, 6);
    chk("t5b_valid_cnt", valid_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_gate_ctrl.md
Name: echo_gate_ctrl

Overview:
- Measurement sequencer directly upstream of the 9-bit ripple distance counter.
- Fires the sensor trigger pulse, synchronises the echo input, and clears the counter before each measurement.
- Gates a one-pulse-per-centimetre tick onto the counter clock while echo is high.
- Captures the settled counter value as distance in cm, with timeout and status reporting.

Parameters:
- TRIG_CYC, 500, trigger high time in clk cycles (10 us @ 50 MHz).
- TICK_CYC, 2900, clk cycles per centimetre tick (58 us @ 50 MHz); must be even and >= 4.
- MAX_CM, 400, ticks allowed in MEASURE before timeout; must be <= 511.
- ECHO_WAIT_CYC, 1_500_000, maximum cycles from trigger fall to echo rise before timeout.
- SETTLE_CYC, 4, cycles waited after the last tick before sampling cnt_q (ripple settle).
- PERIOD_CYC, 3_000_000, auto-repeat interval (used only with AUTO_TRIG_EN).

Ports:
- clk  in  1  system clock.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  measurement request; level sampled in IDLE.
- echo  in  1  raw sensor echo, asynchronous to clk.
- cnt_q  in  9  counter output Q[8:0].
- trig  out  1  sensor trigger pulse.
- cnt_clear  out  1  active-high clear to the counter.
- cnt_clk  out  1  gated tick, drives counter clk.
- dist_cm  out  9  last captured distance in cm.
- dist_valid  out  1  one-cycle pulse when dist_cm updates.
- timeout  out  1  last measurement failed; held until the next measurement starts.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous, clear_n=0:
  - State = IDLE.
  - trig=0, cnt_clk=0, cnt_clear=1, dist_cm=0, dist_valid=0, timeout=0, busy=0.
  - Echo synchroniser = 0; all internal counters = 0.
  - Reset mid-operation aborts immediately; no capture occurs.
- Echo: 2-FF synchroniser gives echo_s. Echo-rise/fall detection uses echo_s against its previous value. Nominal 2-cycle input latency.
- IDLE:
  - cnt_clear=1.
  - start=1 -> TRIG; timeout is cleared on this transition.
- TRIG:
  - trig=1, cnt_clear=1, for exactly TRIG_CYC cycles.
  - Then -> WAIT_ECHO with trig=0 and cnt_clear=0.
- WAIT_ECHO:
  - echo_s rise -> MEASURE.
  - ECHO_WAIT_CYC cycles elapsed without a rise -> FAIL.
- MEASURE:
  - Tick phase counter runs 0..TICK_CYC-1 and wraps.
  - cnt_clk=1 while phase < TICK_CYC/2, else 0.
  - Each completed pulse increments internal tick count tc (9 bit).
  - echo_s fall -> SETTLE; cnt_clk is forced to 0 the same cycle. A partial high pulse therefore completes the count; no pulse is emitted if the fall lands in the low half.
  - tc reaches MAX_CM with echo still high -> FAIL; cnt_clk forced to 0.
- SETTLE:
  - Wait SETTLE_CYC cycles, then -> CAPTURE.
- CAPTURE (1 cycle):
  - dist_cm <= cnt_q; dist_valid=1.
  - -> HOLDOFF.
- FAIL (1 cycle):
  - timeout <= 1; dist_cm unchanged; dist_valid stays 0.
  - -> HOLDOFF.
- HOLDOFF:
  - Waits for echo_s=0, then -> IDLE. This guards against re-trigger while the sensor is still echoing.
- Other rules:
  - start is ignored while busy.
  - start held high re-triggers on the first IDLE cycle.
  - cnt_clk, trig and cnt_clear are registered outputs, glitch-free.
  - An echo already high on entry to WAIT_ECHO is not a rise; the controller waits for low then high.

Optional Feature:
- Macro: AUTO_TRIG_EN.
- Defined:
  - A free-running period counter forces an internal start every PERIOD_CYC cycles.
  - If the pulse lands while busy, it is held pending and taken on return to IDLE.
  - The external start port still works.
- Undefined:
  - Measurements start only from the start port.
  - PERIOD_CYC is unused and no period counter is synthesised.

Test Plan:
Bench parameters: TRIG_CYC=10, TICK_CYC=20, MAX_CM=30, ECHO_WAIT_CYC=200, SETTLE_CYC=4; a behavioural ripple counter model is attached.
1. Reset, then start pulse -> trig high for exactly 10 cycles; cnt_clear=1 throughout TRIG, then 0.
2. Echo high for 250 cycles after the trigger -> 12 full cnt_clk pulses plus 1 partial high pulse; dist_cm=13, one dist_valid pulse, timeout=0.
3. Echo never rises -> FAIL after 200 cycles in WAIT_ECHO; timeout=1, dist_cm keeps the prior value (13), busy drops after HOLDOFF.
4. Echo held high for 1000 cycles -> FAIL after 30 ticks with cnt_clk stopped; remains in HOLDOFF until echo falls, then busy=0.
5. clear_n pulsed low mid-MEASURE -> all outputs at reset values within the same cycle; the next start yields a correct fresh measurement.
6. With AUTO_TRIG_EN and PERIOD_CYC=600, no start -> trig fires every 600 cycles; a period pulse during busy is deferred to IDLE.
